// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl: SPART processor-side bus master.
// Programs the baud divisor, drains RX with optional echo, and round-robins TX with the user port.
module spart_bus_ctrl #(
   parameter int CLK_HZ = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] br_cfg,
   input  logic       echo_en,
   output logic       iocs_n,
   output logic       iorw_n,
   output logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   input  logic       tx_q_full,
   input  logic       rx_q_empty,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   input  logic       tx_req,
   input  logic [7:0] tx_byte,
   output logic       tx_ack
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CFG_LO  = 3'd1;
   localparam logic [2:0] S_CFG_HI  = 3'd2;
   localparam logic [2:0] S_RX_RD   = 3'd3;
   localparam logic [2:0] S_ECHO_WR = 3'd4;
   localparam logic [2:0] S_USR_WR  = 3'd5;
   // Truncating division reproduces the 50 MHz divisor table exactly.
   localparam logic [12:0] DIV_9600   = 13'(CLK_HZ / 9600);
   localparam logic [12:0] DIV_19200  = 13'(CLK_HZ / 19200);
   localparam logic [12:0] DIV_38400  = 13'(CLK_HZ / 38400);
   localparam logic [12:0] DIV_115200 = 13'(CLK_HZ / 115200);
   logic [2:0]  r_state, w_next;
   logic [1:0]  r_cfg_q, r_sel, w_sel;
   logic [12:0] w_div;
   logic [7:0]  r_echo_buf, r_rx_byte, w_wdata;
   logic        r_echo_pend, r_rr_last, r_rx_valid;
   logic        w_r_el, w_u_el, w_gnt_u, w_gnt_r, w_act, w_wr;
   always_comb begin
      w_sel   = (r_state == S_CFG_LO) ? br_cfg : r_sel;
      w_div   = (w_sel == 2'd0) ? DIV_9600 : (w_sel == 2'd1) ? DIV_19200 :
                (w_sel == 2'd2) ? DIV_38400 : DIV_115200;
      w_r_el  = !rx_q_empty && !r_echo_pend;
      w_u_el  = tx_req && !tx_q_full;
      w_gnt_u = w_u_el && (!w_r_el || !r_rr_last);
      w_gnt_r = w_r_el && !w_gnt_u;
      w_next  = (r_state == S_CFG_LO) ? S_CFG_HI :
                (r_state != S_IDLE) ? S_IDLE :
                (br_cfg != r_cfg_q) ? S_CFG_LO :
                (r_echo_pend && !tx_q_full) ? S_ECHO_WR :
                w_gnt_u ? S_USR_WR :
                w_gnt_r ? S_RX_RD : S_IDLE;
      w_wdata = (r_state == S_CFG_LO) ? w_div[7:0] :
                (r_state == S_CFG_HI) ? {3'b000, w_div[12:8]} :
                (r_state == S_ECHO_WR) ? r_echo_buf : tx_byte;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_CFG_LO;
         r_cfg_q     <= 2'b00;
         r_sel       <= 2'b00;
         r_echo_pend <= 1'b0;
         r_echo_buf  <= 8'h00;
         r_rr_last   <= 1'b0;
         r_rx_byte   <= 8'h00;
         r_rx_valid  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_rx_valid <= (r_state == S_RX_RD);
         if (r_state == S_CFG_LO) r_sel <= br_cfg;
         // A br_cfg change between the two writes leaves cfg_q stale and forces another pass.
         if (r_state == S_CFG_HI) r_cfg_q <= r_sel;
         if (r_state == S_RX_RD) begin
            r_rx_byte <= databus;
            if (echo_en) begin
               r_echo_buf  <= databus;
               r_echo_pend <= 1'b1;
            end
         end
         if (r_state == S_ECHO_WR) r_echo_pend <= 1'b0;
         if (r_state == S_IDLE && w_next == S_USR_WR) r_rr_last <= 1'b1;
         else if (r_state == S_IDLE && w_next == S_RX_RD) r_rr_last <= 1'b0;
      end
   end
   // Bus strobes are gated by rst_n so an async reset releases the bus without waiting for a clock.
   assign w_act   = rst_n && (r_state != S_IDLE);
   assign w_wr    = rst_n && (r_state inside {S_CFG_LO, S_CFG_HI, S_ECHO_WR, S_USR_WR});
   assign iocs_n  = !w_act;
   assign iorw_n  = !w_wr;
   assign ioaddr  = !rst_n ? 2'b00 : (r_state == S_CFG_LO) ? 2'b10 :
                    (r_state == S_CFG_HI) ? 2'b11 : 2'b00;
   assign databus = w_wr ? w_wdata : 8'hzz;
   assign tx_ack  = rst_n && (r_state == S_USR_WR);
   assign rx_byte = r_rx_byte;
   assign rx_valid = r_rx_valid;
endmodule

// File: tb/tb_spart_bus_ctrl.sv
// tb_spart_bus_ctrl: randomized and directed checks of spart_bus_ctrl against a transaction-level SPART model.
module tb_spart_bus_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic [1:0] br_cfg = 2'b11;
   logic       echo_en = 1'b0, tx_q_full = 1'b0, rx_q_empty = 1'b1, tx_req = 1'b0;
   logic [7:0] tx_byte = 8'h00, rx_data = 8'h00;
   logic       iocs_n, iorw_n, rx_valid, tx_ack;
   logic [1:0] ioaddr;
   logic [7:0] rx_byte;
   wire  [7:0] databus;

   typedef struct {int cyc; bit ack; bit rw; bit [1:0] a; bit [7:0] d;} acc_t;
   acc_t       acc[$];
   logic [7:0] rxq[$], rxv[$];
   int         rxv_cyc[$];
   bit         full_hist[$];
   int         cyc, ack_total, n_tests = 0, n_fail = 0;
   bit         rd_now = 1'b0, hold_req = 1'b0;

   spart_bus_ctrl #(.CLK_HZ(50000000)) dut (
      .clk(clk), .rst_n(rst_n), .br_cfg(br_cfg), .echo_en(echo_en),
      .iocs_n(iocs_n), .iorw_n(iorw_n), .ioaddr(ioaddr), .databus(databus),
      .tx_q_full(tx_q_full), .rx_q_empty(rx_q_empty), .rx_byte(rx_byte),
      .rx_valid(rx_valid), .tx_req(tx_req), .tx_byte(tx_byte), .tx_ack(tx_ack)
   );

   // SPART side of the bus: answer buffer reads, otherwise leave the bus to the pull-ups.
   assign databus = (rst_n && !iocs_n && iorw_n) ? rx_data : 8'hzz;
   for (genvar g = 0; g < 8; g++) begin : g_pu
      pullup (databus[g]);
   end

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic refresh();
      if (!rd_now) rx_data = (rxq.size() > 0) ? rxq[0] : 8'h00;
      rx_q_empty = (rxq.size() == 0);
   endtask

   task automatic clear_log();
      acc = {}; rxv = {}; rxv_cyc = {}; full_hist = {};
      cyc = 0; ack_total = 0;
   endtask

   task automatic step();
      acc_t e;
      logic [7:0] junk;
      full_hist.push_back(tx_q_full);
      @(negedge clk);
      cyc++;
      rd_now = 1'b0;
      if (!iocs_n) begin
         e.cyc = cyc; e.ack = tx_ack; e.rw = iorw_n; e.a = ioaddr;
         e.d = iorw_n ? rx_data : databus;
         acc.push_back(e);
         if (iorw_n && ioaddr == 2'b00 && rxq.size() > 0) begin
            junk = rxq.pop_front();
            rd_now = 1'b1;
         end
      end
      if (tx_ack) ack_total++;
      if (rx_valid) begin
         rxv.push_back(rx_byte);
         rxv_cyc.push_back(cyc);
      end
      if (tx_ack && !hold_req) tx_req = 1'b0;
      refresh();
   endtask

   task automatic test_reset();
      br_cfg = 2'b11; echo_en = 1'b0; tx_q_full = 1'b0; tx_req = 1'b0;
      rxq = {}; refresh();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++; if (iocs_n !== 1'b1) begin n_fail++; $display("FAIL reset_iocs_n: got %b want 1", iocs_n); end
      n_tests++; if (iorw_n !== 1'b1) begin n_fail++; $display("FAIL reset_iorw_n: got %b want 1", iorw_n); end
      n_tests++; if (ioaddr !== 2'b00) begin n_fail++; $display("FAIL reset_ioaddr: got %b want 00", ioaddr); end
      n_tests++; if (databus !== 8'hFF) begin n_fail++; $display("FAIL reset_databus_released: got %h want FF (pulled)", databus); end
      n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
      n_tests++; if (tx_ack !== 1'b0) begin n_fail++; $display("FAIL reset_tx_ack: got %b want 0", tx_ack); end
      n_tests++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
      @(posedge clk); #1 rst_n = 1'b1;
      clear_log();
      repeat (8) step();
      n_tests++; if (acc.size() !== 2) begin n_fail++; $display("FAIL cfg115200_count: got %0d want 2", acc.size()); end
      if (acc.size() >= 2) begin
         n_tests++;
         if (acc[0].cyc !== 1 || acc[0].rw !== 1'b0 || acc[0].a !== 2'b10 || acc[0].d !== 8'hB2) begin
            n_fail++; $display("FAIL cfg115200_lo: got cyc%0d rw%b a%b d%h want cyc1 rw0 a10 dB2", acc[0].cyc, acc[0].rw, acc[0].a, acc[0].d);
         end
         n_tests++;
         if (acc[1].cyc !== 2 || acc[1].rw !== 1'b0 || acc[1].a !== 2'b11 || acc[1].d !== 8'h01) begin
            n_fail++; $display("FAIL cfg115200_hi: got cyc%0d rw%b a%b d%h want cyc2 rw0 a11 d01", acc[1].cyc, acc[1].rw, acc[1].a, acc[1].d);
         end
      end
   endtask

   task automatic test_reconfig();
      clear_log();
      br_cfg = 2'b00;
      repeat (6) step();
      n_tests++; if (acc.size() !== 2) begin n_fail++; $display("FAIL reconfig_count: got %0d want 2", acc.size()); end
      if (acc.size() >= 2) begin
         n_tests++;
         if (acc[0].rw !== 1'b0 || acc[0].a !== 2'b10 || acc[0].d !== 8'h58) begin
            n_fail++; $display("FAIL reconfig_lo: got rw%b a%b d%h want rw0 a10 d58", acc[0].rw, acc[0].a, acc[0].d);
         end
         n_tests++;
         if (acc[1].cyc !== acc[0].cyc + 1 || acc[1].rw !== 1'b0 || acc[1].a !== 2'b11 || acc[1].d !== 8'h14) begin
            n_fail++; $display("FAIL reconfig_hi: got cyc%0d rw%b a%b d%h want cyc%0d rw0 a11 d14", acc[1].cyc, acc[1].rw, acc[1].a, acc[1].d, acc[0].cyc + 1);
         end
      end
   endtask

   task automatic test_echo();
      clear_log();
      echo_en = 1'b1;
      rxq.push_back(8'h41); refresh();
      repeat (8) step();
      n_tests++; if (acc.size() !== 2) begin n_fail++; $display("FAIL echo_count: got %0d want 2", acc.size()); end
      n_tests++; if (rxv.size() !== 1) begin n_fail++; $display("FAIL echo_rx_valid_pulses: got %0d want 1", rxv.size()); end
      if (acc.size() >= 2 && rxv.size() >= 1) begin
         n_tests++;
         if (acc[0].rw !== 1'b1 || acc[0].a !== 2'b00) begin
            n_fail++; $display("FAIL echo_read: got rw%b a%b want rw1 a00", acc[0].rw, acc[0].a);
         end
         n_tests++;
         if (rxv[0] !== 8'h41 || rxv_cyc[0] !== acc[0].cyc + 1) begin
            n_fail++; $display("FAIL echo_rx_byte: got %h at cyc%0d want 41 at cyc%0d", rxv[0], rxv_cyc[0], acc[0].cyc + 1);
         end
         n_tests++;
         if (acc[1].rw !== 1'b0 || acc[1].a !== 2'b00 || acc[1].d !== 8'h41 || acc[1].ack !== 1'b0 || acc[1].cyc < acc[0].cyc + 2) begin
            n_fail++; $display("FAIL echo_write: got rw%b a%b d%h ack%b cyc%0d want rw0 a00 d41 ack0 after cyc%0d", acc[1].rw, acc[1].a, acc[1].d, acc[1].ack, acc[1].cyc, acc[0].cyc + 1);
         end
      end
      echo_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp[$], b;
      int g, last_rd;
      clear_log();
      echo_en = 1'b0; hold_req = 1'b1; tx_byte = 8'h5A; tx_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b = 8'($urandom);
         rxq.push_back(b); exp.push_back(b);
      end
      refresh();
      g = 0;
      while (rxq.size() > 0 && g < 80) begin step(); g++; end
      n_tests++; if (g >= 80) begin n_fail++; $display("FAIL rr_drain: got timeout want rx drained"); end
      hold_req = 1'b0; tx_req = 1'b0;
      repeat (4) step();
      n_tests++;
      if (acc.size() < 2 || !(acc[0].ack || acc[1].ack)) begin
         n_fail++; $display("FAIL rr_user_latency: got no user write in first 2 accesses want one");
      end
      last_rd = -1;
      foreach (acc[i]) if (acc[i].rw) last_rd = i;
      for (int i = 1; i <= last_rd; i++) begin
         n_tests++;
         if (acc[i].rw === acc[i-1].rw) begin
            n_fail++; $display("FAIL rr_alternate: got rw%b twice at access %0d want alternation", acc[i].rw, i);
         end
      end
      foreach (acc[i]) if (!acc[i].rw) begin
         n_tests++;
         if (acc[i].ack !== 1'b1 || acc[i].d !== 8'h5A || acc[i].a !== 2'b00) begin
            n_fail++; $display("FAIL rr_user_write: got ack%b a%b d%h want ack1 a00 d5A", acc[i].ack, acc[i].a, acc[i].d);
         end
      end
      n_tests++; if (rxv.size() !== exp.size()) begin n_fail++; $display("FAIL rr_rx_count: got %0d want %0d", rxv.size(), exp.size()); end
      foreach (rxv[i]) if (i < exp.size()) begin
         n_tests++;
         if (rxv[i] !== exp[i]) begin n_fail++; $display("FAIL rr_rx_byte: got %h want %h", rxv[i], exp[i]); end
      end
   endtask

   task automatic test_flow();
      int g, n_rd, n_echo, n_usr;
      clear_log();
      echo_en = 1'b1; tx_q_full = 1'b1; hold_req = 1'b0; tx_byte = 8'h7E; tx_req = 1'b1;
      rxq.push_back(8'hA1); rxq.push_back(8'hA2); refresh();
      repeat (10) step();
      n_tests++; if (acc.size() !== 1) begin n_fail++; $display("FAIL flow_blocked_count: got %0d want 1", acc.size()); end
      n_tests++;
      if (acc.size() < 1 || acc[0].rw !== 1'b1) begin n_fail++; $display("FAIL flow_first_read: got no read want read of A1"); end
      tx_q_full = 1'b0;
      repeat (3) step();
      n_tests++;
      if (acc.size() < 2 || acc[1].rw !== 1'b0 || acc[1].ack !== 1'b0 || acc[1].d !== 8'hA1) begin
         n_fail++; $display("FAIL flow_echo_first: got size%0d want echo write A1 as second access", acc.size());
      end
      g = 0;
      while ((rxq.size() > 0 || tx_req) && g < 40) begin step(); g++; end
      n_tests++; if (g >= 40) begin n_fail++; $display("FAIL flow_drain: got timeout want drained"); end
      repeat (6) step();
      n_rd = 0; n_echo = 0; n_usr = 0;
      foreach (acc[i]) begin
         if (acc[i].rw) n_rd++;
         else if (acc[i].ack) n_usr++;
         else n_echo++;
      end
      n_tests++;
      if (n_rd !== 2 || n_echo !== 2 || n_usr !== 1) begin
         n_fail++; $display("FAIL flow_counts: got rd%0d echo%0d usr%0d want rd2 echo2 usr1", n_rd, n_echo, n_usr);
      end
      echo_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      hold_req = 1'b0; tx_byte = 8'hC3; tx_req = 1'b1;
      @(posedge clk); #1;
      n_tests++;
      if (iocs_n !== 1'b0 || tx_ack !== 1'b1 || databus !== 8'hC3) begin
         n_fail++; $display("FAIL mid_usr_active: got cs%b ack%b d%h want cs0 ack1 dC3", iocs_n, tx_ack, databus);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (iocs_n !== 1'b1 || iorw_n !== 1'b1 || tx_ack !== 1'b0 || databus !== 8'hFF) begin
         n_fail++; $display("FAIL mid_reset_release: got cs%b rw%b ack%b d%h want cs1 rw1 ack0 dFF", iocs_n, iorw_n, tx_ack, databus);
      end
      tx_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clear_log();
      repeat (8) step();
      n_tests++;
      if (acc.size() !== 2 || acc[0].a !== 2'b10 || acc[0].d !== 8'h58 || acc[1].a !== 2'b11 || acc[1].d !== 8'h14) begin
         n_fail++; $display("FAIL mid_reconfig: got %0d accesses want 2 (10/58, 11/14)", acc.size());
      end
      n_tests++; if (ack_total !== 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d want 0", ack_total); end
   endtask

   task automatic test_random(input bit e);
      logic [7:0] exp_user[$], pushed[$], echo_exp[$], b, junk;
      int g, n_usr;
      acc_t x;
      clear_log();
      echo_en = e; hold_req = 1'b0; tx_req = 1'b0; n_usr = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (!tx_req && !tx_ack && $urandom_range(3) == 0) begin
            tx_byte = 8'($urandom); tx_req = 1'b1; exp_user.push_back(tx_byte);
         end
         tx_q_full = ($urandom_range(2) == 0);
         if ($urandom_range(3) == 0 && rxq.size() < 4) begin
            b = 8'($urandom); rxq.push_back(b); pushed.push_back(b); refresh();
         end
      end
      tx_q_full = 1'b0;
      g = 0;
      while ((rxq.size() > 0 || tx_req) && g < 200) begin step(); g++; end
      n_tests++; if (g >= 200) begin n_fail++; $display("FAIL rand_drain: got timeout want drained (echo_en=%b)", e); end
      repeat (6) step();
      foreach (acc[i]) begin
         x = acc[i];
         n_tests++; if (x.a !== 2'b00) begin n_fail++; $display("FAIL rand_addr: got %b want 00", x.a); end
         if (i > 0) begin
            n_tests++;
            if (x.cyc - acc[i-1].cyc < 2) begin n_fail++; $display("FAIL rand_gap: got %0d want >=2", x.cyc - acc[i-1].cyc); end
         end
         if (x.rw) begin
            n_tests++;
            if (e && echo_exp.size() > 0) begin n_fail++; $display("FAIL rand_read_during_echo: got read at cyc%0d want none", x.cyc); end
            if (e) echo_exp.push_back(x.d);
         end else begin
            n_tests++;
            if (full_hist[x.cyc-1] !== 1'b0) begin n_fail++; $display("FAIL rand_write_when_full: got write at cyc%0d want none", x.cyc); end
            n_tests++;
            if (x.ack) begin
               n_usr++;
               if (exp_user.size() == 0 || x.d !== exp_user[0]) begin
                  n_fail++; $display("FAIL rand_user_data: got %h want %h", x.d, exp_user.size() ? exp_user[0] : 8'h00);
               end
               if (exp_user.size() > 0) junk = exp_user.pop_front();
            end else begin
               if (echo_exp.size() == 0 || x.d !== echo_exp[0]) begin
                  n_fail++; $display("FAIL rand_echo_data: got %h want %h", x.d, echo_exp.size() ? echo_exp[0] : 8'h00);
               end
               if (echo_exp.size() > 0) junk = echo_exp.pop_front();
            end
         end
      end
      n_tests++; if (exp_user.size() !== 0) begin n_fail++; $display("FAIL rand_user_unserved: got %0d left want 0", exp_user.size()); end
      n_tests++; if (echo_exp.size() !== 0) begin n_fail++; $display("FAIL rand_echo_unserved: got %0d left want 0", echo_exp.size()); end
      n_tests++; if (ack_total !== n_usr) begin n_fail++; $display("FAIL rand_ack_count: got %0d want %0d", ack_total, n_usr); end
      n_tests++; if (rxv.size() !== pushed.size()) begin n_fail++; $display("FAIL rand_rx_count: got %0d want %0d", rxv.size(), pushed.size()); end
      foreach (rxv[i]) if (i < pushed.size()) begin
         n_tests++;
         if (rxv[i] !== pushed[i]) begin n_fail++; $display("FAIL rand_rx_byte: got %h want %h", rxv[i], pushed[i]); end
      end
      echo_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reconfig();
      test_echo();
      test_back_to_back();
      test_flow();
      test_reset_mid();
      test_random(1'b0);
      test_random(1'b1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
